// File: rtl/line_word_streamer_if.sv
// Request/response bundle for line_word_streamer: one captured cache line in,
// a critical-word-first stream of words out.
interface line_word_streamer_if #(
  parameter int W = 8,
  parameter int N = 128
);
  localparam int SEL_W = $clog2(N);

  logic                 in_valid;
  logic                 in_ready;
  logic [W*N-1:0]       in_line;
  logic [SEL_W-1:0]     in_sel;
  logic [SEL_W:0]       in_len;
  logic                 out_valid;
  logic                 out_ready;
  logic [W-1:0]         out_data;
  logic [SEL_W-1:0]     out_idx;
  logic                 out_last;
  logic                 err;

  modport master (
    output in_valid, in_line, in_sel, in_len, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last, err
  );

  modport slave (
    input  in_valid, in_line, in_sel, in_len, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last, err
  );
endinterface

// File: rtl/line_word_streamer.sv
// Captures one N-word cache line and streams in_len words from in_sel,
// wrapping modulo N, over a valid/ready handshake.
module line_word_streamer #(
  parameter int W = 8,
  parameter int N = 128
) (
  input  logic                 clk,
  input  logic                 rst_n,
  line_word_streamer_if.slave  bus
);
  localparam int SEL_W = $clog2(N);
  localparam logic [SEL_W:0]   N_L      = (SEL_W+1)'(N);
  localparam logic [SEL_W:0]   LEN_ONE  = (SEL_W+1)'(1);
  localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(N-1);
  localparam logic [SEL_W-1:0] IDX_ONE  = SEL_W'(1);

  typedef enum logic {IDLE, STREAM} state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     line_q [N];
  logic [SEL_W-1:0] idx_q;
  logic [SEL_W:0]   beat_q;
  logic [SEL_W:0]   len_q;
  logic             err_q, err_d;

  logic req_fire, req_legal, out_fire, last_beat;

  assign req_fire  = bus.in_valid && (state_q == IDLE);
  assign req_legal = ({1'b0, bus.in_sel} < N_L) && (bus.in_len != '0) && (bus.in_len <= N_L);
  assign out_fire  = (state_q == STREAM) && bus.out_ready;
  assign last_beat = (beat_q == (len_q - LEN_ONE));
  assign err_d     = req_fire && !req_legal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (req_fire && req_legal) state_d = STREAM;
      STREAM: if (out_fire && last_beat) state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == STREAM);
    bus.out_data  = '0;
    bus.out_idx   = '0;
    bus.out_last  = 1'b0;
    bus.err       = err_q;
    if (state_q == STREAM) begin
      bus.out_data = line_q[idx_q];
      bus.out_idx  = idx_q;
      bus.out_last = last_beat;
    end
  end

  // Index wraps at N-1 so non-power-of-two line sizes never address a missing channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N; i++) line_q[i] <= '0;
      idx_q  <= '0;
      beat_q <= '0;
      len_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= err_d;
      if (req_fire && req_legal) begin
        for (int unsigned i = 0; i < N; i++) line_q[i] <= bus.in_line[i*W +: W];
        idx_q  <= bus.in_sel;
        beat_q <= '0;
        len_q  <= bus.in_len;
      end else if (out_fire) begin
        idx_q  <= (idx_q == IDX_LAST) ? '0 : idx_q + IDX_ONE;
        beat_q <= beat_q + LEN_ONE;
      end
    end
  end
endmodule
